// File: rtl/result_tx_framer.sv
// Frames each accepted result word into SYNC, SEQ, LEN, data (MSB byte first), CHK
// and writes it one byte per cycle into the uart_tx6 FIFO, holding while the FIFO is full.
module result_tx_framer #(
    parameter int          DATA_W    = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] result_data,
    input  logic              result_valid,
    output logic              result_ready,
    output logic [7:0]        tx_data,
    output logic              tx_write,
    input  logic              tx_buffer_full,
    output logic              busy,
    output logic [7:0]        seq_num
);

    // state  | meaning
    // IDLE   | waiting for a result word, result_ready high
    // SYNC   | sending SYNC_BYTE
    // SEQ    | sending the sequence number
    // LEN    | sending the data byte count
    // DATA   | sending captured word, byte index counts down to 0
    // CHK    | sending two's-complement checksum, then back to IDLE

    localparam int         NBYTES   = DATA_W / 8;
    localparam logic [7:0] LEN_BYTE = 8'(NBYTES);
    localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_SEQ,
        S_LEN,
        S_DATA,
        S_CHK
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] word_q, word_nxt;
    logic [1:0]        idx_q, idx_nxt;
    logic [7:0]        acc_q, acc_nxt;
    logic [7:0]        seq_q, seq_nxt;
    logic [7:0]        tx_byte;
    logic [7:0]        data_byte;
    logic              write_en;

    assign data_byte = 8'(word_q >> {idx_q, 3'b000});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            word_q <= '0;
            idx_q  <= '0;
            acc_q  <= '0;
            seq_q  <= '0;
        end else begin
            state  <= state_nxt;
            word_q <= word_nxt;
            idx_q  <= idx_nxt;
            acc_q  <= acc_nxt;
            seq_q  <= seq_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        word_nxt  = word_q;
        idx_nxt   = idx_q;
        acc_nxt   = acc_q;
        seq_nxt   = seq_q;
        tx_byte   = 8'h00;
        write_en  = (state != S_IDLE) && !tx_buffer_full;

        case (state)
            S_IDLE: begin
                if (result_valid) begin
                    word_nxt  = result_data;
                    acc_nxt   = 8'h00;
                    idx_nxt   = LAST_IDX;
                    state_nxt = S_SYNC;
                end
            end
            S_SYNC: begin
                tx_byte = SYNC_BYTE;
                if (write_en) state_nxt = S_SEQ;
            end
            S_SEQ: begin
                tx_byte = seq_q;
                if (write_en) begin
                    acc_nxt   = acc_q + seq_q;
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                tx_byte = LEN_BYTE;
                if (write_en) begin
                    acc_nxt   = acc_q + LEN_BYTE;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                tx_byte = data_byte;
                if (write_en) begin
                    acc_nxt = acc_q + data_byte;
                    if (idx_q == 2'd0) state_nxt = S_CHK;
                    else               idx_nxt   = idx_q - 2'd1;
                end
            end
            S_CHK: begin
                tx_byte = ~acc_q + 8'd1;
                if (write_en) begin
                    seq_nxt   = seq_q + 8'd1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Reset gates the outputs combinationally so nothing leaks out while reset_n is low.
    assign tx_write     = write_en && reset_n;
    assign tx_data      = reset_n ? tx_byte : 8'h00;
    assign result_ready = reset_n && (state == S_IDLE);
    assign busy         = reset_n && (state != S_IDLE);
    assign seq_num      = seq_q;

endmodule

// File: tb/tb_result_tx_framer.sv
// Bench for result_tx_framer: table vectors, byte scoreboard fed at stimulus time,
// and directed sequences for backpressure, held valid, reset mid-packet and SEQ wrap.
module tb_result_tx_framer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] result_data;
    logic        result_valid;
    logic        result_ready;
    logic [7:0]  tx_data;
    logic        tx_write;
    logic        tx_buffer_full;
    logic        busy;
    logic [7:0]  seq_num;

    always #5 clk = ~clk;

    result_tx_framer #(.DATA_W(16), .SYNC_BYTE(8'hA5)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .result_data    (result_data),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .tx_data        (tx_data),
        .tx_write       (tx_write),
        .tx_buffer_full (tx_buffer_full),
        .busy           (busy),
        .seq_num        (seq_num)
    );

    typedef struct {
        logic [15:0] data;
        logic [7:0]  chk;
    } vec_t;

    vec_t        vecs[5];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_seq;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] chk_model(input logic [7:0] s, input logic [15:0] d);
        logic [7:0] a;
        a = s + 8'd2 + d[15:8] + d[7:0];
        return ~a + 8'd1;
    endfunction

    task automatic push_pkt(input logic [7:0] s, input logic [15:0] d, input logic [7:0] c);
        exp_q.push_back(8'hA5);
        exp_q.push_back(s);
        exp_q.push_back(8'h02);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(c);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && !result_ready; i++) @(negedge clk);
        if (!result_ready) check("ready_timeout", 32'(result_ready), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
        check(name, {exp_q.size() != 0, busy}, 32'd0);
    endtask

    // Drives one result and checks the uninterrupted 6-byte write run plus the IDLE gap.
    task automatic send_pkt(input logic [15:0] d, input logic [7:0] c);
        push_pkt(exp_seq, d, c);
        wait_ready();
        result_data  = d;
        result_valid = 1'b1;
        @(posedge clk);
        #1 result_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("write_run", {busy, result_ready, tx_write}, 32'b101);
        end
        @(negedge clk);
        check("idle_gap", {busy, result_ready, tx_write}, 32'b010);
        exp_seq = exp_seq + 8'd1;
        check("seq_num", 32'(seq_num), 32'(exp_seq));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("rst_outputs", {tx_write, result_ready, busy, tx_data}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        exp_seq = 8'h00;
        @(negedge clk);
        check("rst_seq", 32'(seq_num), 32'd0);
        check("rst_ready", {busy, result_ready, tx_write}, 32'b010);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        result_data    = 16'h0000;
        result_valid   = 1'b0;
        tx_buffer_full = 1'b0;
        exp_seq        = 8'h00;

        vecs[0] = '{16'h1234, 8'hB8};
        vecs[1] = '{16'hFFFF, 8'hFF};
        vecs[2] = '{16'h0000, 8'hFC};
        vecs[3] = '{16'h8001, 8'h7A};
        vecs[4] = '{16'hA5A5, 8'hB0};

        fork
            forever begin
                @(negedge clk);
                if (tx_write) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_write: got byte %02h expected no write", tx_data);
                    end else begin
                        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        do_reset();

        for (int v = 0; v < 5; v++) send_pkt(vecs[v].data, vecs[v].chk);
        check("table_drain", exp_q.size(), 0);

        // result_valid held high with a new word during a packet
        begin
            int cnt;
            logic [15:0] wa, wb;
            wa = 16'h1357;
            wb = 16'h2468;
            push_pkt(exp_seq, wa, chk_model(exp_seq, wa));
            push_pkt(exp_seq + 8'd1, wb, chk_model(exp_seq + 8'd1, wb));
            wait_ready();
            result_data  = wa;
            result_valid = 1'b1;
            @(posedge clk);
            #1 result_data = wb;
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!result_ready && cnt < 30);
            check("held_gap_cycles", cnt, 7);
            check("held_queue", exp_q.size(), 6);
            @(posedge clk);
            #1 result_valid = 1'b0;
            wait_drain("held_drain");
            exp_seq = exp_seq + 8'd2;
            check("held_seq", 32'(seq_num), 32'(exp_seq));
        end

        // reset mid-packet, after SYNC and SEQ have been written
        exp_q.push_back(8'hA5);
        exp_q.push_back(exp_seq);
        wait_ready();
        result_data  = 16'hC0DE;
        result_valid = 1'b1;
        @(posedge clk);
        #1 result_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("midrst_outputs", {tx_write, result_ready, busy, tx_data}, 32'd0);
        check("midrst_popped", exp_q.size(), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        exp_seq = 8'h00;
        @(negedge clk);
        check("midrst_seq", 32'(seq_num), 32'd0);
        check("midrst_state", {busy, result_ready}, 32'b01);
        repeat (3) begin
            @(negedge clk);
            check("midrst_nowrite", 32'(tx_write), 32'd0);
        end
        send_pkt(16'h5AC3, chk_model(8'h00, 16'h5AC3));

        // three-cycle backpressure while in SEQ
        do_reset();
        push_pkt(8'h00, 16'hBEEF, chk_model(8'h00, 16'hBEEF));
        result_data  = 16'hBEEF;
        result_valid = 1'b1;
        @(posedge clk);
        #1 result_valid = 1'b0;
        @(posedge clk);
        #1 tx_buffer_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_hold", {tx_write, busy, tx_data}, {1'b0, 1'b1, 8'h00});
            check("stall_queue", exp_q.size(), 5);
        end
        @(posedge clk);
        #1 tx_buffer_full = 1'b0;
        wait_drain("stall_drain");
        exp_seq = 8'h01;
        check("stall_seq", 32'(seq_num), 32'd1);

        // 257 packets back-to-back: SEQ wraps FF -> 00
        do_reset();
        for (int p = 0; p < 257; p++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if (p == 255) check("seq_before_ff", 32'(seq_num), 32'hFF);
            send_pkt(d, chk_model(exp_seq, d));
        end
        check("seq_after_wrap", 32'(seq_num), 32'd1);

        // random backpressure, including mid-DATA
        begin
            int   acc_cnt;
            logic rdy;
            acc_cnt = 0;
            for (int c = 0; c < 3000 && !(acc_cnt == 8 && exp_q.size() == 0 && !busy); c++) begin
                @(negedge clk);
                rdy = result_ready;
                @(posedge clk);
                #1;
                if (result_valid && rdy) begin
                    push_pkt(exp_seq, result_data, chk_model(exp_seq, result_data));
                    exp_seq = exp_seq + 8'd1;
                    acc_cnt++;
                    result_valid = 1'b0;
                end
                tx_buffer_full = ($urandom_range(0, 2) == 0);
                if (!result_valid && acc_cnt < 8) begin
                    result_data  = 16'($urandom);
                    result_valid = 1'b1;
                end
            end
            tx_buffer_full = 1'b0;
            result_valid   = 1'b0;
            check("rbp_packets", acc_cnt, 8);
            wait_drain("rbp_drain");
            check("rbp_seq", 32'(seq_num), 32'(exp_seq));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
